// File: rtl/t03_mem_pkg.sv
// Shared width codes, FSM states and steering helpers for the data memory handler.
package t03_mem_pkg;

    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request attributes latched when a legal request is accepted.
    typedef struct packed {
        logic [2:0] width;
        logic [1:0] off;
        logic       we;
    } req_t;

    function automatic logic req_illegal(input logic rd, input logic wr,
                                         input logic [2:0] w, input logic [1:0] off);
        logic bad;
        bad = rd & wr;
        case (w)
            W_B, W_BU: ;
            W_H, W_HU: bad = bad | off[0];
            W_W:       bad = bad | (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        // Unsigned widths only make sense for loads.
        if (wr && w[2]) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [3:0] strobe(input logic [2:0] w, input logic [1:0] off);
        logic [3:0] s;
        case (w)
            W_B, W_BU: s = 4'b0001 << off;
            W_H, W_HU: s = 4'b0011 << off;
            default:   s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] w, input logic [31:0] sd);
        logic [31:0] d;
        case (w)
            W_B:     d = {4{sd[7:0]}};
            W_H:     d = {2{sd[15:0]}};
            default: d = sd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/t03_load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign/zero extends it.
module t03_load_extend
    import t03_mem_pkg::*;
(
    input  logic [31:0] dat,
    input  logic [1:0]  off,
    input  logic [2:0]  width,
    output logic [31:0] ext
);

    logic [31:0] lane;

    assign lane = dat >> {off, 3'b000};

    always_comb begin
        ext = '0;
        case (width)
            W_B:     ext = {{24{lane[7]}}, lane[7:0]};
            W_H:     ext = {{16{lane[15]}}, lane[15:0]};
            W_W:     ext = dat;
            W_BU:    ext = {24'h0, lane[7:0]};
            W_HU:    ext = {16'h0, lane[15:0]};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/t03_data_mem_handler.sv
// Converts one datapath load/store into a single word-bus transaction and stalls the CPU until it
// completes, aborts on timeout, or is rejected as illegal.
module t03_data_mem_handler
    import t03_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  data_width,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        freeze,
    output logic        mem_err,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t      state, state_nx;
    req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] load_d, adr_d, dat_o_d, ext;
    logic [3:0]  sel_d;
    logic        err_d, cyc_d, we_d;
    logic        request, illegal, timed_out;

    assign request   = mem_read | mem_write;
    assign illegal   = req_illegal(mem_read, mem_write, data_width, addr[1:0]);
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Stall while a request waits in IDLE or the bus is busy; DONE lets the CPU advance.
    assign freeze = ~rst & (((state == IDLE) & request) | (state == REQ));

    t03_load_extend u_load_extend (
        .dat   (bus_dat_i),
        .off   (req_q.off),
        .width (req_q.width),
        .ext   (ext)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (request) state_nx = illegal ? DONE : REQ;
            REQ:     if (bus_ack || timed_out) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs, request latch and timeout counter.
    always_comb begin
        req_d   = req_q;
        cnt_d   = cnt_q;
        load_d  = load_data;
        err_d   = 1'b0;
        cyc_d   = bus_cyc;
        we_d    = bus_we;
        sel_d   = bus_sel;
        adr_d   = bus_adr;
        dat_o_d = bus_dat_o;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (request) begin
                    if (illegal) begin
                        err_d  = 1'b1;
                        load_d = '0;
                    end else begin
                        req_d.width = data_width;
                        req_d.off   = addr[1:0];
                        req_d.we    = mem_write;
                        cyc_d       = 1'b1;
                        we_d        = mem_write;
                        sel_d       = strobe(data_width, addr[1:0]);
                        adr_d       = {addr[31:2], 2'b00};
                        dat_o_d     = mem_write ? store_lanes(data_width, store_data) : 32'h0;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    cyc_d  = 1'b0;
                    cnt_d  = '0;
                    load_d = req_q.we ? 32'h0 : ext;
                end else if (timed_out) begin
                    cyc_d  = 1'b0;
                    cnt_d  = '0;
                    err_d  = 1'b1;
                    load_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            cnt_q     <= '0;
            load_data <= '0;
            mem_err   <= 1'b0;
            bus_cyc   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_adr   <= '0;
            bus_dat_o <= '0;
        end else begin
            req_q     <= req_d;
            cnt_q     <= cnt_d;
            load_data <= load_d;
            mem_err   <= err_d;
            bus_cyc   <= cyc_d;
            bus_we    <= we_d;
            bus_sel   <= sel_d;
            bus_adr   <= adr_d;
            bus_dat_o <= dat_o_d;
        end
    end

endmodule
